// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU command front-end: opcodes, FSM states,
// flag indices, IEEE-754 single field widths and the command record.
package fpu_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 23;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned CMD_W  = 2 * WORD_W + OP_W;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_MUL = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV = 4'd3;

  localparam int unsigned FLAG_ZERO   = 0;
  localparam int unsigned FLAG_INF    = 1;
  localparam int unsigned FLAG_NAN    = 2;
  localparam int unsigned FLAG_BAD_OP = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLD
  } seq_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] num1;
    logic [WORD_W-1:0] num2;
    logic [OP_W-1:0]   op;
  } fpu_cmd_t;

  // Denormals (exp==0, mant!=0) deliberately do not count as zero.
  function automatic logic [3:0] classify(input logic [EXP_W-1:0]  exp_f,
                                          input logic [MANT_W-1:0] mant_f,
                                          input logic [OP_W-1:0]   op);
    logic [3:0] f;
    f = '0;
    f[FLAG_NAN]    = (exp_f == '1) && (mant_f != '0);
    f[FLAG_INF]    = (exp_f == '1) && (mant_f == '0);
    f[FLAG_ZERO]   = (exp_f == '0) && (mant_f == '0);
    f[FLAG_BAD_OP] = (op > OP_DIV);
    return f;
  endfunction

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Synchronous command FIFO (DEPTH x W) with full/empty flags and
// asynchronous active-low reset; the head entry is presented combinationally.
module fpu_cmd_fifo
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = CMD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full     = (count == CNT_W'(DEPTH));
    empty    = (count == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    pop_data = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Command front-end for the combinational FPU: queues commands, holds operands
// for SETTLE cycles, then captures a back-pressurable result. FPU_SEQ_FLAGS_EN adds out_flags.
module fpu_op_sequencer
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_num1,
  input  logic [WORD_W-1:0] in_num2,
  input  logic [OP_W-1:0]   in_op,
  output logic [WORD_W-1:0] fpu_num1,
  output logic [WORD_W-1:0] fpu_num2,
  output logic [OP_W-1:0]   fpu_op,
  input  logic [WORD_W-1:0] fpu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_result,
  output logic [OP_W-1:0]   out_op
`ifdef FPU_SEQ_FLAGS_EN
  ,
  output logic [3:0]        out_flags
`endif
);

  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  seq_state_e       state;
  logic [CNT_W-1:0] settle_cnt;
  fpu_cmd_t         in_cmd;
  fpu_cmd_t         head_cmd;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  always_comb begin
    in_cmd      = '0;
    in_cmd.num1 = in_num1;
    in_cmd.num2 = in_num2;
    in_cmd.op   = in_op;
    in_ready    = !fifo_full;
    pop = !fifo_empty &&
          ((state == ST_IDLE) || ((state == ST_HOLD) && out_ready));
  end

  fpu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (in_cmd),
    .pop       (pop),
    .pop_data  (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      fpu_num1   <= '0;
      fpu_num2   <= '0;
      fpu_op     <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_op     <= '0;
`ifdef FPU_SEQ_FLAGS_EN
      out_flags  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            fpu_num1   <= head_cmd.num1;
            fpu_num2   <= head_cmd.num2;
            fpu_op     <= head_cmd.op;
            settle_cnt <= CNT_W'(SETTLE - 1);
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (settle_cnt == '0) begin
            out_result <= fpu_result;
            out_op     <= fpu_op;
            out_valid  <= 1'b1;
`ifdef FPU_SEQ_FLAGS_EN
            out_flags  <= classify(fpu_result[WORD_W-2 -: EXP_W],
                                   fpu_result[MANT_W-1:0], fpu_op);
`endif
            state      <= ST_HOLD;
          end else begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          // Consuming the result and issuing the next command share one edge.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (pop) begin
              fpu_num1   <= head_cmd.num1;
              fpu_num2   <= head_cmd.num2;
              fpu_op     <= head_cmd.op;
              settle_cnt <= CNT_W'(SETTLE - 1);
              state      <= ST_ISSUE;
            end else begin
              state      <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench for fpu_op_sequencer with a stand-in FPU that only
// returns a valid result once its operands have been stable for SETTLE cycles.
module tb_fpu_op_sequencer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_num1 = '0;
  logic [31:0] in_num2 = '0;
  logic [3:0]  in_op = '0;
  logic [31:0] fpu_num1;
  logic [31:0] fpu_num2;
  logic [3:0]  fpu_op;
  logic [31:0] fpu_result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [3:0]  out_op;
`ifdef FPU_SEQ_FLAGS_EN
  logic [3:0]  out_flags;
`endif

  fpu_op_sequencer #(
    .DEPTH  (DEPTH),
    .SETTLE (SETTLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_num1    (in_num1),
    .in_num2    (in_num2),
    .in_op      (in_op),
    .fpu_num1   (fpu_num1),
    .fpu_num2   (fpu_num2),
    .fpu_op     (fpu_op),
    .fpu_result (fpu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op)
`ifdef FPU_SEQ_FLAGS_EN
    ,
    .out_flags  (out_flags)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stand-in datapath: known IEEE cases, bad-op marker, else a simple mixing function.
  function automatic logic [31:0] fpu_model(input logic [31:0] n1, input logic [31:0] n2,
                                            input logic [3:0] op);
    if (op > 4'd3)                                          return 32'h000B00B5;
    if (op == 4'd0 && n1 == 32'h3F800000 && n2 == 32'h40000000) return 32'h40400000;
    if (op == 4'd2 && n1 == 32'h7FC00000)                   return 32'h7FC00000;
    if (op == 4'd1 && n1 == n2)                             return 32'h00000000;
    return n1 ^ {n2[15:0], n2[31:16]} ^ {28'd0, op};
  endfunction

  logic [67:0] prev_cmd = '0;
  int unsigned age = 0;
  always @(negedge clk) begin
    if ({fpu_num1, fpu_num2, fpu_op} != prev_cmd) age <= 0;
    else if (age < 1000) age <= age + 1;
    prev_cmd <= {fpu_num1, fpu_num2, fpu_op};
  end
  assign fpu_result = (age >= SETTLE - 1) ? fpu_model(fpu_num1, fpu_num2, fpu_op)
                                          : 32'hDEADBEEF;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  op;
  } exp_t;
  exp_t exp_q[$];
  int   got_cyc[$];
  bit   mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h expected none", out_result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("order_result", out_result, e.res);
        check("order_op", {28'd0, out_op}, {28'd0, e.op});
        got_cyc.push_back(cyc);
      end
    end
  end

  task automatic push_cmd(input logic [31:0] n1, input logic [31:0] n2, input logic [3:0] op);
    int unsigned t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1; in_num1 = n1; in_num2 = n2; in_op = op;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("push_accept", {31'd0, in_ready}, 32'd1);
    if (in_ready) begin
      exp_q.push_back('{res: fpu_model(n1, n2, op), op: op});
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int unsigned t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(name, exp_q.size(), 32'd0);
  endtask

  task automatic wait_out_valid(input string name);
    int unsigned t;
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check(name, {31'd0, out_valid}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] n1;
    logic [31:0] n2;
    logic [3:0]  op;
    logic [31:0] res;
    logic [3:0]  flags;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int   lat;
    int   accepted;
    bit   stable;
    bit   stale;
    logic [31:0] r0;
    logic [31:0] n0;

    vecs[0] = '{32'h3F800000, 32'h40000000, 4'h0, 32'h40400000, 4'b0000};
    vecs[1] = '{32'h7FC00000, 32'h3F800000, 4'h2, 32'h7FC00000, 4'b0100};
    vecs[2] = '{32'h3F800000, 32'h3F800000, 4'h1, 32'h00000000, 4'b0001};
    vecs[3] = '{32'h3F800000, 32'h40000000, 4'h7, 32'h000B00B5, 4'b1000};
    vecs[4] = '{32'h12345678, 32'h00000000, 4'h3, 32'h1234567B, 4'b0000};
    vecs[5] = '{32'h000000F0, 32'h00010000, 4'h0, 32'h000000F1, 4'b0000};
    vecs[6] = '{32'h7F800000, 32'h00000000, 4'h0, 32'h7F800000, 4'b0010};
    vecs[7] = '{32'h00000001, 32'h00000002, 4'hF, 32'h000B00B5, 4'b1000};

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_fpu_op", {28'd0, fpu_op}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_fpu_num1", fpu_num1, 32'd0);

    // Single operations: latency, result, opcode, flags.
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("vec_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; in_num1 = vecs[i].n1; in_num2 = vecs[i].n2; in_op = vecs[i].op;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
        @(posedge clk);
        #1 lat++;
      end
      check("vec_latency", lat, SETTLE + 1);
      check("vec_result", out_result, vecs[i].res);
      check("vec_out_op", {28'd0, out_op}, {28'd0, vecs[i].op});
      check("vec_fpu_num2", fpu_num2, vecs[i].n2);
`ifdef FPU_SEQ_FLAGS_EN
      check("vec_flags", {28'd0, out_flags}, {28'd0, vecs[i].flags});
`endif
      @(posedge clk);
      #1 check("vec_consumed", {31'd0, out_valid}, 32'd0);
    end

    // Fill with out_ready low: 1 in flight + DEPTH queued, then back-pressure.
    out_ready = 1'b0;
    mon_en = 1'b1;
    accepted = 0;
    got_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_num1 = 32'h01000000 * (i + 1);
      in_num2 = 32'h00000100 * (i + 1);
      in_op = 4'(i % 4);
      if (in_ready) begin
        accepted++;
        exp_q.push_back('{res: fpu_model(in_num1, in_num2, in_op), op: in_op});
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
    check("fill_accepted", accepted, DEPTH + 1);
    @(negedge clk);
    check("fill_in_ready_low", {31'd0, in_ready}, 32'd0);
    wait_out_valid("fill_out_valid");
    check("fill_first_result", out_result, fpu_model(32'h01000000, 32'h00000100, 4'd0));
    check("fill_first_num1", fpu_num1, 32'h01000000);
    r0 = out_result;
    n0 = fpu_num1;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (out_result !== r0 || fpu_num1 !== n0 || out_valid !== 1'b1) stable = 1'b0;
    end
    check("hold_stable", {31'd0, stable}, 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain("fill_drain");
    check("fill_count", got_cyc.size(), 32'd5);
    if (got_cyc.size() == 5)
      for (int k = 1; k < 5; k++)
        check("throughput_gap", got_cyc[k] - got_cyc[k-1], SETTLE + 1);
    @(negedge clk);
    check("fill_in_ready_back", {31'd0, in_ready}, 32'd1);

    // Simultaneous push and pop at occupancy 2 on the HOLD->ISSUE edge.
    @(posedge clk);
    #1 out_ready = 1'b0;
    push_cmd(32'hA0000001, 32'h00000011, 4'h0);
    push_cmd(32'hA0000002, 32'h00000022, 4'h1);
    push_cmd(32'hA0000003, 32'h00000033, 4'h2);
    wait_out_valid("pp_out_valid");
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_num1 = 32'hA0000004; in_num2 = 32'h00000044; in_op = 4'h3;
    @(negedge clk);
    check("pp_in_ready_before", {31'd0, in_ready}, 32'd1);
    check("pp_occ_before", 32'(dut.u_fifo.count), 32'd2);
    exp_q.push_back('{res: fpu_model(in_num1, in_num2, in_op), op: in_op});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("pp_occ_after", 32'(dut.u_fifo.count), 32'd2);
    check("pp_in_ready_after", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain("pp_drain");

    // Ten back-to-back commands, pointers wrap; order checked by the monitor.
    for (int i = 0; i < 10; i++)
      push_cmd(32'hC0000000 + 32'(i * 3), 32'h00005000 + 32'(i), 4'(i % 5));
    wait_drain("wrap_drain");

    // Asynchronous reset while a result is held and commands are queued.
    @(posedge clk);
    #1 out_ready = 1'b0;
    push_cmd(32'h0F0F0F0F, 32'h00001234, 4'h2);
    push_cmd(32'h0E0E0E0E, 32'h00005678, 4'h2);
    push_cmd(32'h0D0D0D0D, 32'h00009ABC, 4'h2);
    wait_out_valid("mid_out_valid");
    #2 rst = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_fpu_op", {28'd0, fpu_op}, 32'd0);
    check("mid_rst_out_result", out_result, 32'd0);
    check("mid_rst_out_op", {28'd0, out_op}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b1;
    stale = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("no_stale_result", {31'd0, stale}, 32'd0);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fpu_op_sequencer.md
# fpu_op_sequencer

Upstream command front-end for the combinational FPU datapath. It accepts operations through a valid/ready handshake and buffers them in a small FIFO. It presents each operation's operands and opcode to the FPU from registers and holds them for a fixed settle window, then captures the FPU result into a registered, back-pressurable output. This lets the long combinational add/mul/div path be timed as a multi-cycle path.

## Interface
- `DEPTH`, default 4: command FIFO entries; power of two, ≥2.
- `SETTLE`, default 2: cycles the operands are held before the result is captured; ≥1.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  command offered.
- `in_ready`  out  1  command accepted when high with in_valid; equals !fifo_full.
- `in_num1`, `in_num2`  in  32  IEEE-754 single operands.
- `in_op`  in  4  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV.
- `fpu_num1`, `fpu_num2`  out  32  registered operands to the FPU.
- `fpu_op`  out  4  registered opcode to the FPU.
- `fpu_result`  in  32  combinational FPU result.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_result`  out  32  captured result.
- `out_op`  out  4  opcode of the captured result.
- `out_flags`  out  4  {bad_op, nan, inf, zero}; present only with `FPU_SEQ_FLAGS_EN`.

## Operation
- FSM states:
  - IDLE: no operation in flight.
  - ISSUE: operands driven; settle counter running.
  - HOLD: out_valid high, waiting for out_ready.
- IDLE → ISSUE: on any cycle with the FIFO non-empty. The FIFO head is popped and loaded into fpu_num1/fpu_num2/fpu_op at that edge. The counter is loaded with SETTLE-1.
- ISSUE: the counter decrements each cycle. On the cycle the counter is 0:
  - fpu_result is captured into out_result, and fpu_op into out_op.
  - flags are computed.
  - the FSM moves to HOLD.
- HOLD, when out_ready=1:
  - FIFO non-empty: pop the next command and go to ISSUE (back-to-back).
  - FIFO empty: go to IDLE.
- HOLD, when out_ready=0: stay in HOLD. out_result, out_op and out_flags stay stable.
- fpu_num*/fpu_op change only on a pop. They hold their last value in IDLE and HOLD.
- FIFO rules:
  - Push when in_valid&&in_ready.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - There is no pass-through when full; in_ready is low at DEPTH entries.
  - Pointers wrap modulo DEPTH. Occupancy is a log2(DEPTH)+1-bit count.
  - Strict FIFO order.
- Opcodes 4–15 are passed through unchanged. The FPU returns 0x000B00B5 for them; bad_op is set.
- Reset (asynchronous, any state, including mid-ISSUE or mid-HOLD):
  - FSM goes to IDLE and the FIFO is emptied. Queued and in-flight commands are discarded.
  - out_valid=0, out_result=0, out_op=0, out_flags=0.
  - fpu_num1=fpu_num2=0, fpu_op=0.
  - in_ready=1 after release.

## Timing
- Command accepted at edge of cycle 0 into an empty, idle block:
  - pop at end of cycle 1.
  - operands valid cycles 2..1+SETTLE.
  - capture at end of cycle 1+SETTLE.
  - out_valid high from cycle 2+SETTLE. This is cycle 4 at the default SETTLE=2.
- Sustained throughput with out_ready=1: one result per SETTLE+1 cycles.
- in_ready depends only on FIFO occupancy. It has no combinational path from in_valid or out_ready.
- out_valid is registered. out_ready reaches only the FSM and pop logic.

## Configuration
- `FPU_SEQ_FLAGS_EN` defined: the out_flags port and classifier are present. Classification of the captured result:
  - nan: exp==8'hFF and mant!=0.
  - inf: exp==8'hFF and mant==0.
  - zero: exp==0 and mant==0. Denormals are not zero.
  - bad_op: op>3.
- `FPU_SEQ_FLAGS_EN` undefined: the out_flags port and classifier logic are absent. All other behaviour is identical.

## Structure
- The shared package `fpu_pkg` holds:
  - opcode constants (ADD, SUB, MUL, DIV).
  - FSM state encoding.
  - flag bit indices.
  - EXP_W=8 and MANT_W=23 field constants.
  - the 68-bit command record width.
- One sub-module, `fpu_cmd_fifo`: DEPTH×68-bit synchronous FIFO with full/empty flags and the same reset.

## Test plan
- Reset: assert rst mid-stream → out_valid=0, in_ready=1, fpu_op=0, out_result=0; no stale result emerges after release.
- ADD single op, num1 0x3F800000, num2 0x40000000, out_ready=1 → out_result 0x40400000 and out_op 0 at cycle 4; flags 0.
- Fill with out_ready=0, DEPTH=4: push 6 ops → 5 accepted (1 in flight, 4 queued), in_ready low; after releasing out_ready, all results emerge in push order.
- Back-pressure: hold out_ready=0 for 10 cycles in HOLD → out_result stable, fpu_num* unchanged; then out_ready=1 → results every 3 cycles.
- Specials: MUL 0x7FC00000×0x3F800000 → nan=1. SUB 0x3F800000−0x3F800000 → out_result 0x00000000, zero=1. op 4'h7 → out_result 0x000B00B5, bad_op=1.
- Simultaneous push/pop at occupancy 2 in the HOLD→ISSUE transition → occupancy stays 2, in_ready stays 1; wrap-around across 10 ops preserves order.
